// File: rtl/alu_pkg.sv
// Shared constants for the 4-bit registered ALU and the logic wrapped around it.
package alu_pkg;

    localparam int ALU_IN_W  = 4;
    localparam int ALU_OUT_W = 8;
    localparam int ALU_LAT   = 2;

    localparam logic [ALU_IN_W-1:0] OP_INCA = 4'b0000;
    localparam logic [ALU_IN_W-1:0] OP_INCB = 4'b0001;
    localparam logic [ALU_IN_W-1:0] OP_TRA  = 4'b0010;
    localparam logic [ALU_IN_W-1:0] OP_TRB  = 4'b0011;
    localparam logic [ALU_IN_W-1:0] OP_DECA = 4'b0100;
    localparam logic [ALU_IN_W-1:0] OP_MUL  = 4'b0101;
    localparam logic [ALU_IN_W-1:0] OP_ADD  = 4'b0110;
    localparam logic [ALU_IN_W-1:0] OP_NOTA = 4'b1000;
    localparam logic [ALU_IN_W-1:0] OP_NOTB = 4'b1001;
    localparam logic [ALU_IN_W-1:0] OP_AND  = 4'b1010;
    localparam logic [ALU_IN_W-1:0] OP_OR   = 4'b1011;
    localparam logic [ALU_IN_W-1:0] OP_XOR  = 4'b1100;
    localparam logic [ALU_IN_W-1:0] OP_XNOR = 4'b1101;
    localparam logic [ALU_IN_W-1:0] OP_NAND = 4'b1110;
    localparam logic [ALU_IN_W-1:0] OP_NOR  = 4'b1111;

endpackage

// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO; the head is visible on rdata_o whenever count_o != 0.
module alu_result_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // NOTE: storage is not reset; only pointers and count are, and the head is qualified by count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Issue credits guarantee room for every capture; the consumer only pops a valid head.
    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && (count_q == (AW+1)'(DEPTH))));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && (count_q == '0)));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues commands to the registered ALU, tracks its fixed latency with a tag pipe,
// and captures results in order into a credit-protected FIFO.
module alu_issue_ctrl #(
    parameter int TAG_W   = 4,
    parameter int RDEPTH  = 4,
    parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [alu_pkg::ALU_IN_W-1:0]   cmd_a,
    input  logic [alu_pkg::ALU_IN_W-1:0]   cmd_b,
    input  logic [alu_pkg::ALU_IN_W-1:0]   cmd_sel,
    input  logic [TAG_W-1:0]               cmd_tag,
    output logic [alu_pkg::ALU_IN_W-1:0]   alu_a,
    output logic [alu_pkg::ALU_IN_W-1:0]   alu_b,
    output logic [alu_pkg::ALU_IN_W-1:0]   alu_sel,
    input  logic [alu_pkg::ALU_OUT_W-1:0]  alu_y,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [alu_pkg::ALU_OUT_W-1:0]  res_y,
    output logic [TAG_W-1:0]               res_tag,
    output logic                           res_zero,
    output logic                           res_neg,
    output logic                           busy
);

    localparam int IN_W  = alu_pkg::ALU_IN_W;
    localparam int OUT_W = alu_pkg::ALU_OUT_W;
    localparam int ENT_W = OUT_W + TAG_W + 2;
    localparam int CNT_W = $clog2(RDEPTH) + 1;
    localparam int OCC_W = $clog2(RDEPTH + ALU_LAT + 1) + 1;

    logic [IN_W-1:0]  alu_a_q, alu_b_q, alu_sel_q;
    logic [ALU_LAT:0] s_valid_q;
    logic [TAG_W-1:0] s_tag_q [ALU_LAT+1];

    logic             accept, pop, capture;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    logic [ENT_W-1:0] cap_data, head_data;
    logic [OUT_W-1:0] head_y;
    logic [TAG_W-1:0] head_tag;
    logic             head_zero, head_neg;

    // Every op in the tag pipe or the FIFO holds one credit until it is popped.
    assign occupancy = OCC_W'($countones(s_valid_q)) + OCC_W'(fifo_count);
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid & res_ready;
    assign cmd_ready = (occupancy - OCC_W'(pop)) < OCC_W'(RDEPTH);
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (occupancy != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            s_valid_q <= '0;
            for (int i = 0; i <= ALU_LAT; i++) s_tag_q[i] <= '0;
        end else begin
            if (accept) begin
                alu_a_q   <= cmd_a;
                alu_b_q   <= cmd_b;
                alu_sel_q <= cmd_sel;
            end
            s_valid_q  <= {s_valid_q[ALU_LAT-1:0], accept};
            s_tag_q[0] <= cmd_tag;
            for (int i = 1; i <= ALU_LAT; i++) s_tag_q[i] <= s_tag_q[i-1];
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;

    // alu_y lines up with the oldest stage, so a valid there marks a result to keep.
    assign capture  = s_valid_q[ALU_LAT];
    assign cap_data = {alu_y, s_tag_q[ALU_LAT], (alu_y == '0), alu_y[OUT_W-1]};

    alu_result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture),
        .wdata_i (cap_data),
        .pop_i   (pop),
        .rdata_o (head_data),
        .count_o (fifo_count)
    );

    assign {head_y, head_tag, head_zero, head_neg} = head_data;

    assign res_y    = res_valid ? head_y   : '0;
    assign res_tag  = res_valid ? head_tag : '0;
    assign res_zero = res_valid & head_zero;
    assign res_neg  = res_valid & head_neg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl driving a behavioural two-register ALU, with an in-order scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int TAG_W  = 4;
    localparam int RDEPTH = 4;

    logic             clk, rst_n;
    logic             cmd_valid, cmd_ready;
    logic [3:0]       cmd_a, cmd_b, cmd_sel;
    logic [TAG_W-1:0] cmd_tag;
    logic [3:0]       alu_a, alu_b, alu_sel;
    logic [7:0]       alu_y;
    logic             res_valid, res_ready;
    logic [7:0]       res_y;
    logic [TAG_W-1:0] res_tag;
    logic             res_zero, res_neg, busy;

    typedef struct packed {
        logic [7:0]       y;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    exp_t       push_e;
    logic [7:0] cur_exp;
    int         n_checks = 0;
    int         n_errors = 0;

    alu_issue_ctrl #(.TAG_W(TAG_W), .RDEPTH(RDEPTH), .ALU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_tag(res_tag), .res_zero(res_zero), .res_neg(res_neg),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_y(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
        logic [7:0] sa, sb, r;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        case (sel)
            OP_INCA: r = sa + 8'd1;
            OP_INCB: r = sb + 8'd1;
            OP_TRA:  r = sa;
            OP_TRB:  r = sb;
            OP_DECA: r = sa - 8'd1;
            OP_MUL:  r = sa * sb;
            OP_ADD:  r = sa + sb;
            OP_NOTA: r = ~sa;
            OP_NOTB: r = ~sb;
            OP_AND:  r = sa & sb;
            OP_OR:   r = sa | sb;
            OP_XOR:  r = sa ^ sb;
            OP_XNOR: r = ~(sa ^ sb);
            OP_NAND: r = ~(sa & sb);
            OP_NOR:  r = ~(sa | sb);
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // ALU input register then output register, no reset.
    logic [3:0] ain_a, ain_b, ain_sel;
    always_ff @(posedge clk) begin
        ain_a   <= alu_a;
        ain_b   <= alu_b;
        ain_sel <= alu_sel;
        alu_y   <= ref_y(ain_a, ain_b, ain_sel);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, compare the head every valid cycle, pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
            end else begin
                if (res_valid) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_res", res_valid, 1'b0);
                    end else begin
                        mon_e = sb_q[0];
                        check("res_y",    res_y,    mon_e.y);
                        check("res_tag",  res_tag,  mon_e.tag);
                        check("res_zero", res_zero, mon_e.y == 8'h00);
                        check("res_neg",  res_neg,  mon_e.y[7]);
                        if (res_ready) void'(sb_q.pop_front());
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    push_e.y   = cur_exp;
                    push_e.tag = cmd_tag;
                    sb_q.push_back(push_e);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                         input logic [TAG_W-1:0] tag, input logic [7:0] exp);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_tag   = tag;
        cur_exp   = exp;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                        input logic [TAG_W-1:0] tag, input logic [7:0] exp);
        bit acc;
        acc = 1'b0;
        drive(a, b, sel, tag, exp);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!acc) check("send_timeout", cmd_ready, 1'b1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            done = !busy && (sb_q.size() == 0);
        end
        if (!done) check("drain_timeout", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         accepts;
        logic [3:0] ra, rb, rs;
        logic [TAG_W-1:0] t;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
        cmd_tag = '0; res_ready = 1'b1; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_res_y",     res_y,     8'h00);
        check("rst_res_tag",   res_tag,   '0);
        check("rst_flags",     {res_zero, res_neg}, 2'b00);
        check("rst_alu_regs",  {alu_a, alu_b, alu_sel}, 12'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // First op: result visible only after the third edge following accept.
        send(4'd3, 4'd2, OP_ADD, 4'd1, 8'h05);
        check("alu_regs_load", {alu_a, alu_b, alu_sel}, {4'd3, 4'd2, OP_ADD});
        @(posedge clk); #1; check("lat_t1", res_valid, 1'b0);
        @(posedge clk); #1; check("lat_t2", res_valid, 1'b0);
        @(posedge clk); #1; check("lat_t3", res_valid, 1'b1);
        wait_drain();

        send(4'b1000, 4'd7, OP_MUL,  4'd2, 8'hC8);
        send(4'b1000, 4'd0, OP_DECA, 4'd3, 8'hF7);
        wait_drain();

        // Eight back-to-back ops at full rate with the consumer always ready.
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) begin
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                rs = 4'($urandom_range(0, 15));
                drive(ra, rb, rs, TAG_W'(k), ref_y(ra, rb, rs));
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 8) check("b2b_cmd_ready", cmd_ready, 1'b1);
            @(posedge clk);
            #1;
            if (k >= 3) check("b2b_res_valid", res_valid, 1'b1);
        end
        cmd_valid = 1'b0;
        wait_drain();

        // Consumer stalled: credits run out after RDEPTH accepts.
        res_ready = 1'b0;
        accepts = 0;
        t = 4'd8;
        ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
        drive(ra, rb, OP_XOR, t, ref_y(ra, rb, OP_XOR));
        for (int c = 0; c < 12; c++) begin
            bit acc;
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                accepts++;
                t = t + 4'd1;
                ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
                drive(ra, rb, OP_XOR, t, ref_y(ra, rb, OP_XOR));
            end
        end
        check("stall_accepts",   accepts,   RDEPTH);
        check("stall_cmd_ready", cmd_ready, 1'b0);
        check("stall_busy",      busy,      1'b1);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        check("ready_on_pop", cmd_ready, 1'b1);
        wait_drain();

        // Unused opcode and an AND with no common bits both report zero.
        ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
        send(ra, rb, 4'b0111, 4'd12, 8'h00);
        send(4'd5, 4'd2, OP_AND, 4'd13, 8'h00);
        wait_drain();

        // Reset with two ops in flight: nothing may surface afterwards.
        send(4'd1, 4'd1, OP_ADD, 4'd14, 8'h02);
        send(4'd2, 4'd1, OP_ADD, 4'd15, 8'h03);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", res_valid, 1'b0);
        end
        check("post_rst_busy",      busy,      1'b0);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        send(4'd6, 4'd1, OP_INCA, 4'd9, 8'h07);
        wait_drain();
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Command-issue and result-capture stage wrapped around the 4-bit registered ALU. It accepts operand/opcode commands on a valid/ready interface and drives the ALU's a/b/sel inputs from registers. It tracks the ALU's fixed pipeline latency with a tag shift register and captures each y into an in-order result FIFO with zero/negative flags. The ALU cannot stall, so issue is credit-limited to keep the FIFO from overflowing.

Parameters:
TAG_W, 4, width of the opaque command tag carried alongside each operation
RDEPTH, 4, result FIFO depth and total credit count (power of 2, >= 2)
ALU_LAT, 2, clock edges from an alu_* change until alu_y is valid (ALU input register plus output register)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted on this edge if cmd_valid
cmd_a  in  4  signed operand A
cmd_b  in  4  signed operand B
cmd_sel  in  4  ALU opcode
cmd_tag  in  TAG_W  tag returned with result
alu_a  out  4  registered, to ALU a
alu_b  out  4  registered, to ALU b
alu_sel  out  4  registered, to ALU sel
alu_y  in  8  signed ALU result
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer takes head
res_y  out  8  signed result
res_tag  out  TAG_W  tag of result
res_zero  out  1  res_y == 0
res_neg  out  1  res_y[7]
busy  out  1  any op in flight or buffered

Behaviour:
- Reset (async assert, sync release on clk): alu_a/alu_b/alu_sel=0, stage valids cleared, FIFO empty; res_valid=0, res_y/res_tag/flags=0, busy=0, cmd_ready=1 once out of reset.
- Accept = cmd_valid & cmd_ready. On accept edge t: alu_a/b/sel <= cmd_a/b/sel; stage s0 <= {1, cmd_tag}. With no accept, alu_* hold their value and s0.valid <= 0; ALU output from such cycles is ignored.
- Stages s0..s[ALU_LAT] shift every clock, no stall. On an edge where s[ALU_LAT].valid=1, write {alu_y, tag, alu_y==0, alu_y[7]} into the FIFO. Default latency: accept edge t, capture edge t+3, res_valid=1 after t+3.
- occupancy = popcount(stage valids) + FIFO count; pop = res_valid & res_ready.
- cmd_ready = (occupancy - pop) < RDEPTH. This is a combinational path from res_ready to cmd_ready and is intentional: it gives full rate (one op per clock) at RDEPTH=4 with res_ready held high.
- A capture can never find the FIFO full; an attempted overflow is an assertion failure.
- Simultaneous capture and pop: both happen, count unchanged. A pop of an empty FIFO is impossible because res_valid=0.
- Results are strictly in accept order. res_* is the FIFO head (first-word-fall-through) and stays stable while res_valid & !res_ready.
- All opcodes pass through unchecked. Unused sel=0111 yields y=0 and is reported normally with res_zero=1.
- Reset mid-operation: in-flight and buffered results are discarded and no res_valid pulse follows. The ALU itself has no reset, but stale y is never captured because the stage valids are cleared.
- busy = (occupancy != 0).

Decomposition:
- Shared package alu_pkg: ALU_IN_W=4, ALU_OUT_W=8, ALU_LAT=2, opcode localparams OP_INCA=0000, OP_INCB=0001, OP_TRA=0010, OP_TRB=0011, OP_DECA=0100, OP_MUL=0101, OP_ADD=0110, OP_NOTA=1000, OP_NOTB=1001, OP_AND=1010, OP_OR=1011, OP_XOR=1100, OP_XNOR=1101, OP_NAND=1110, OP_NOR=1111.
- One sub-module: alu_result_fifo, a synchronous first-word-fall-through FIFO, width ALU_OUT_W+TAG_W+2, depth RDEPTH, with count output.
- The bench instantiates the ALU plus alu_issue_ctrl together.

Test Plan:
- Reset, then a=3, b=2, sel=0110, tag=1 accepted at edge t -> res_valid rises after edge t+3, res_y=8'h05, tag=1, zero=0, neg=0.
- a=-8 (4'b1000), b=7, sel=0101 -> res_y=8'hC8 (-56), res_neg=1; then sel=0100 with a=-8 -> res_y=8'hF7 (-9).
- 8 back-to-back commands (tags 0..7), res_ready=1 throughout -> cmd_ready never drops, results 0..7 in order, one per clock from t+3.
- res_ready=0, cmd_valid held high -> exactly 4 accepts then cmd_ready=0, busy=1. Raise res_ready -> cmd_ready=1 in the same cycle as the first pop, and results drain in order.
- sel=0111 with any operands, and sel=1010 with a=5, b=2 -> res_y=0, res_zero=1 for both.
- Accept 2 commands, pull rst_n low 1 cycle later, release -> no res_valid ever asserted for them, busy=0, cmd_ready=1.
